// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, colours, scan state encoding and pipeline payload.
package vga_pkg;

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;

    localparam int unsigned VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int unsigned VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam int unsigned RGB_W = 12;

    localparam logic [RGB_W-1:0] VGA_FG_COLOR = 12'hFFF;
    localparam logic [RGB_W-1:0] VGA_BG_COLOR = 12'h000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1
    } scan_state_t;

    // Per-pixel control bits that travel alongside the RAM read
    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
        logic clr;
    } pix_ctl_t;

    // Counter width able to hold 0..total-1
    function automatic int unsigned cnt_width(input int unsigned total);
        return (total <= 2) ? 1 : $clog2(total);
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters with registered active/sync flags, frame origin and frame pulse.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP
) (
    input  logic clk,
    input  logic resetn,
    input  logic enable_i,
    output logic active_o,
    output logic hs_o,
    output logic vs_o,
    output logic frame_pulse_o,
    output logic frame_start_c,
    output logic scan_next_c
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_W      = cnt_width(H_TOTAL);
    localparam int unsigned V_W      = cnt_width(V_TOTAL);
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC - 1;

    scan_state_t    state_q, state_d;
    logic [H_W-1:0] h_q, h_d;
    logic [V_W-1:0] v_q, v_d;
    logic           active_q, active_d;
    logic           hs_q, hs_d;
    logic           vs_q, vs_d;
    logic           fp_q, fp_d;
    logic           scan_d;
    logic           h_last, v_last;

    assign h_last = (h_q == H_W'(H_TOTAL - 1));
    assign v_last = (v_q == V_W'(V_TOTAL - 1));

    // Next state and counters; flags decoded from the next counter values so they align with them
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        case (state_q)
            ST_IDLE: begin
                h_d = '0;
                v_d = '0;
                if (enable_i) state_d = ST_SCAN;
            end
            ST_SCAN: begin
                if (h_last) begin
                    h_d = '0;
                    if (v_last) begin
                        v_d = '0;
                        if (!enable_i) state_d = ST_IDLE;
                    end else begin
                        v_d = v_q + V_W'(1);
                    end
                end else begin
                    h_d = h_q + H_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                h_d     = '0;
                v_d     = '0;
            end
        endcase

        scan_d   = (state_d == ST_SCAN);
        active_d = scan_d && (h_d < H_W'(H_ACTIVE)) && (v_d < V_W'(V_ACTIVE));
        hs_d     = scan_d && (h_d >= H_W'(HS_START)) && (h_d <= H_W'(HS_END));
        vs_d     = scan_d && (v_d >= V_W'(VS_START)) && (v_d <= V_W'(VS_END));
        fp_d     = scan_d && (v_d == V_W'(V_ACTIVE));
    end

    // State, counter and flag registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            h_q      <= '0;
            v_q      <= '0;
            active_q <= 1'b0;
            hs_q     <= 1'b0;
            vs_q     <= 1'b0;
            fp_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            h_q      <= h_d;
            v_q      <= v_d;
            active_q <= active_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            fp_q     <= fp_d;
        end
    end

    assign active_o      = active_q;
    assign hs_o          = hs_q;
    assign vs_o          = vs_q;
    assign frame_pulse_o = fp_q;
    assign scan_next_c   = scan_d;
    assign frame_start_c = scan_d && (h_d == '0) && (v_d == '0);

endmodule

// File: rtl/framebuffer_scanout.sv
// Pixel-clock reader of the monochrome framebuffer: raster addressing, latency-matched
// sync/colour outputs and optional clear-after-read.
module framebuffer_scanout
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = VGA_H_ACTIVE,
    parameter int unsigned H_FP       = VGA_H_FP,
    parameter int unsigned H_SYNC     = VGA_H_SYNC,
    parameter int unsigned H_BP       = VGA_H_BP,
    parameter int unsigned V_ACTIVE   = VGA_V_ACTIVE,
    parameter int unsigned V_FP       = VGA_V_FP,
    parameter int unsigned V_SYNC     = VGA_V_SYNC,
    parameter int unsigned V_BP       = VGA_V_BP,
    parameter int unsigned ADDR_WIDTH = $clog2(H_ACTIVE * V_ACTIVE),
    parameter int unsigned RD_LATENCY = 1,
    parameter logic [11:0] FG_COLOR   = VGA_FG_COLOR,
    parameter logic [11:0] BG_COLOR   = VGA_BG_COLOR
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  enable,
    input  logic                  clear_en,
    output logic [ADDR_WIDTH-1:0] fb_rd_addr,
    output logic                  fb_rd_en,
    input  logic                  fb_rd_data,
    output logic [ADDR_WIDTH-1:0] fb_clr_addr,
    output logic                  fb_clr_en,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  de,
    output logic [11:0]           rgb,
    output logic                  frame_pulse
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(H_ACTIVE * V_ACTIVE - 1);

    logic active_s, hs_s, vs_s;
    logic frame_start_c, scan_next_c;

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  clr_frame_q, clr_frame_d;

    pix_ctl_t              ctl_s0;
    pix_ctl_t              ctl_dly_q  [RD_LATENCY];
    logic [ADDR_WIDTH-1:0] addr_dly_q [RD_LATENCY];
    pix_ctl_t              ctl_out;
    logic [ADDR_WIDTH-1:0] addr_out;

    logic                  de_q, hsync_q, vsync_q, clr_en_q;
    logic [11:0]           rgb_q, rgb_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q;

    vga_timing_gen #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk           (clk),
        .resetn        (resetn),
        .enable_i      (enable),
        .active_o      (active_s),
        .hs_o          (hs_s),
        .vs_o          (vs_s),
        .frame_pulse_o (frame_pulse),
        .frame_start_c (frame_start_c),
        .scan_next_c   (scan_next_c)
    );

    // Incremental raster address, restarted at the frame origin and held at the last pixel
    always_comb begin
        addr_d      = addr_q;
        clr_frame_d = clr_frame_q;
        if (frame_start_c || !scan_next_c) begin
            addr_d = '0;
        end else if (active_s && (addr_q != LAST_ADDR)) begin
            addr_d = addr_q + ADDR_WIDTH'(1);
        end
        if (frame_start_c) clr_frame_d = clear_en;
    end

    // Address and per-frame clear flag registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q      <= '0;
            clr_frame_q <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            clr_frame_q <= clr_frame_d;
        end
    end

    // Stage-0 control bits accompanying the read strobe
    always_comb begin
        ctl_s0        = '0;
        ctl_s0.active = active_s;
        ctl_s0.hs     = hs_s;
        ctl_s0.vs     = vs_s;
        ctl_s0.clr    = active_s && clr_frame_q;
    end

    // Delay line matching the RAM read latency
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < RD_LATENCY; i++) begin
                ctl_dly_q[i]  <= '0;
                addr_dly_q[i] <= '0;
            end
        end else begin
            ctl_dly_q[0]  <= ctl_s0;
            addr_dly_q[0] <= addr_q;
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                ctl_dly_q[i]  <= ctl_dly_q[i-1];
                addr_dly_q[i] <= addr_dly_q[i-1];
            end
        end
    end

    assign ctl_out  = ctl_dly_q[RD_LATENCY-1];
    assign addr_out = addr_dly_q[RD_LATENCY-1];

    // Colour mapping of the returned pixel bit, blanked outside active video
    always_comb begin
        rgb_d = '0;
        if (ctl_out.active) rgb_d = fb_rd_data ? FG_COLOR : BG_COLOR;
    end

    // Output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            de_q       <= 1'b0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            rgb_q      <= '0;
            clr_en_q   <= 1'b0;
            clr_addr_q <= '0;
        end else begin
            de_q       <= ctl_out.active;
            hsync_q    <= ~ctl_out.hs;
            vsync_q    <= ~ctl_out.vs;
            rgb_q      <= rgb_d;
            clr_en_q   <= ctl_out.clr;
            clr_addr_q <= addr_out;
        end
    end

    assign fb_rd_en    = active_s;
    assign fb_rd_addr  = addr_q;
    assign de          = de_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign rgb         = rgb_q;
    assign fb_clr_en   = clr_en_q;
    assign fb_clr_addr = clr_addr_q;

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Bench for framebuffer_scanout on a shrunken 15x9 raster (8x4 visible) with a 1-cycle RAM model.
module tb_framebuffer_scanout;

    localparam int unsigned AW    = 5;
    localparam int unsigned NPIX  = 32;
    localparam int          FRAME = 135;
    localparam int          HMAX  = 512;

    logic          clk      = 1'b0;
    logic          resetn   = 1'b0;
    logic          enable   = 1'b0;
    logic          clear_en = 1'b0;
    logic [AW-1:0] fb_rd_addr, fb_clr_addr;
    logic          fb_rd_en, fb_clr_en;
    logic          fb_rd_data = 1'b0;
    logic          hsync, vsync, de, frame_pulse;
    logic [11:0]   rgb;

    // Pixel a holds a[0]
    logic [NPIX-1:0] mem = 32'hAAAA_AAAA;

    framebuffer_scanout #(
        .H_ACTIVE   (8),
        .H_FP       (2),
        .H_SYNC     (3),
        .H_BP       (2),
        .V_ACTIVE   (4),
        .V_FP       (1),
        .V_SYNC     (2),
        .V_BP       (2),
        .ADDR_WIDTH (AW),
        .RD_LATENCY (1),
        .FG_COLOR   (12'hFFF),
        .BG_COLOR   (12'h000)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .enable      (enable),
        .clear_en    (clear_en),
        .fb_rd_addr  (fb_rd_addr),
        .fb_rd_en    (fb_rd_en),
        .fb_rd_data  (fb_rd_data),
        .fb_clr_addr (fb_clr_addr),
        .fb_clr_en   (fb_clr_en),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .rgb         (rgb),
        .frame_pulse (frame_pulse)
    );

    always #5 clk = ~clk;

    // Single-port RAM model: 1-cycle read, write-0 clear
    always @(posedge clk) begin
        if (fb_rd_en) fb_rd_data <= mem[fb_rd_addr];
        if (fb_clr_en) mem[fb_clr_addr] <= 1'b0;
    end

    typedef struct {
        int          k;
        logic        rd_en;
        logic [AW-1:0] addr;
        logic        de;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        fp;
    } vec_t;

    vec_t vecs[$];

    int n_pass, n_checks, k;

    logic          h_rd_en  [HMAX];
    logic [AW-1:0] h_rd_addr[HMAX];
    logic          h_clr_en [HMAX];
    logic [AW-1:0] h_clr_addr[HMAX];
    logic          h_de     [HMAX];
    logic [11:0]   h_rgb    [HMAX];
    logic          h_hs     [HMAX];
    logic          h_vs     [HMAX];
    logic          h_fp     [HMAX];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (k=%0d): got %0h, want %0h", name, k, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        k++;
        @(negedge clk);
        if (k < HMAX) begin
            h_rd_en[k]    = fb_rd_en;
            h_rd_addr[k]  = fb_rd_addr;
            h_clr_en[k]   = fb_clr_en;
            h_clr_addr[k] = fb_clr_addr;
            h_de[k]       = de;
            h_rgb[k]      = rgb;
            h_hs[k]       = hsync;
            h_vs[k]       = vsync;
            h_fp[k]       = frame_pulse;
        end
    endtask

    task automatic run_to(input int target);
        while (k < target) step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_en"},    32'(fb_rd_en),    32'd0);
        check({tag, "_rd_addr"},  32'(fb_rd_addr),  32'd0);
        check({tag, "_clr_en"},   32'(fb_clr_en),   32'd0);
        check({tag, "_clr_addr"}, 32'(fb_clr_addr), 32'd0);
        check({tag, "_de"},       32'(de),          32'd0);
        check({tag, "_rgb"},      32'(rgb),         32'd0);
        check({tag, "_hsync"},    32'(hsync),       32'd1);
        check({tag, "_vsync"},    32'(vsync),       32'd1);
        check({tag, "_fp"},       32'(frame_pulse), 32'd0);
    endtask

    initial begin
        n_pass   = 0;
        n_checks = 0;
        k        = 0;
        for (int i = 0; i < HMAX; i++) begin
            h_rd_en[i] = 1'b0; h_rd_addr[i] = '0; h_clr_en[i] = 1'b0; h_clr_addr[i] = '0;
            h_de[i] = 1'b0; h_rgb[i] = '0; h_hs[i] = 1'b1; h_vs[i] = 1'b1; h_fp[i] = 1'b0;
        end

        // k: rd_en addr de rgb hsync vsync frame_pulse, sampled after the k-th clock of the scan
        vecs.push_back(vec_t'{  1, 1'b1, 5'd0,  1'b0, 12'h000, 1'b1, 1'b1, 1'b0});
        vecs.push_back(vec_t'{  2, 1'b1, 5'd1,  1'b0, 12'h000, 1'b1, 1'b1, 1'b0});
        vecs.push_back(vec_t'{  3, 1'b1, 5'd2,  1'b1, 12'h000, 1'b1, 1'b1, 1'b0});
        vecs.push_back(vec_t'{  4, 1'b1, 5'd3,  1'b1, 12'hFFF, 1'b1, 1'b1, 1'b0});
        vecs.push_back(vec_t'{  9, 1'b0, 5'd8,  1'b1, 12'h000, 1'b1, 1'b1, 1'b0});
        vecs.push_back(vec_t'{ 10, 1'b0, 5'd8,  1'b1, 12'hFFF, 1'b1, 1'b1, 1'b0});
        vecs.push_back(vec_t'{ 11, 1'b0, 5'd8,  1'b0, 12'h000, 1'b1, 1'b1, 1'b0});
        vecs.push_back(vec_t'{ 13, 1'b0, 5'd8,  1'b0, 12'h000, 1'b0, 1'b1, 1'b0});
        vecs.push_back(vec_t'{ 15, 1'b0, 5'd8,  1'b0, 12'h000, 1'b0, 1'b1, 1'b0});
        vecs.push_back(vec_t'{ 16, 1'b1, 5'd8,  1'b0, 12'h000, 1'b1, 1'b1, 1'b0});
        vecs.push_back(vec_t'{ 17, 1'b1, 5'd9,  1'b0, 12'h000, 1'b1, 1'b1, 1'b0});
        vecs.push_back(vec_t'{ 18, 1'b1, 5'd10, 1'b1, 12'h000, 1'b1, 1'b1, 1'b0});
        vecs.push_back(vec_t'{ 19, 1'b1, 5'd11, 1'b1, 12'hFFF, 1'b1, 1'b1, 1'b0});
        vecs.push_back(vec_t'{ 28, 1'b0, 5'd16, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0});
        vecs.push_back(vec_t'{ 53, 1'b1, 5'd31, 1'b1, 12'hFFF, 1'b1, 1'b1, 1'b0});
        vecs.push_back(vec_t'{ 54, 1'b0, 5'd31, 1'b1, 12'h000, 1'b1, 1'b1, 1'b0});
        vecs.push_back(vec_t'{ 55, 1'b0, 5'd31, 1'b1, 12'hFFF, 1'b1, 1'b1, 1'b0});
        vecs.push_back(vec_t'{ 60, 1'b0, 5'd31, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0});
        vecs.push_back(vec_t'{ 61, 1'b0, 5'd31, 1'b0, 12'h000, 1'b1, 1'b1, 1'b1});
        vecs.push_back(vec_t'{ 75, 1'b0, 5'd31, 1'b0, 12'h000, 1'b0, 1'b1, 1'b1});
        vecs.push_back(vec_t'{ 76, 1'b0, 5'd31, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0});
        vecs.push_back(vec_t'{ 78, 1'b0, 5'd31, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0});
        vecs.push_back(vec_t'{107, 1'b0, 5'd31, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0});
        vecs.push_back(vec_t'{108, 1'b0, 5'd31, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0});
        vecs.push_back(vec_t'{135, 1'b0, 5'd31, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0});

        // Reset values while held in reset
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        // Release reset and start scanning on the next edge
        resetn = 1'b1;
        enable = 1'b1;

        foreach (vecs[i]) begin
            run_to(vecs[i].k);
            check("tbl_rd_en",  32'(fb_rd_en),    32'(vecs[i].rd_en));
            check("tbl_rd_addr",32'(fb_rd_addr),  32'(vecs[i].addr));
            check("tbl_de",     32'(de),          32'(vecs[i].de));
            check("tbl_rgb",    32'(rgb),         32'(vecs[i].rgb));
            check("tbl_hsync",  32'(hsync),       32'(vecs[i].hs));
            check("tbl_vsync",  32'(vsync),       32'(vecs[i].vs));
            check("tbl_fp",     32'(frame_pulse), 32'(vecs[i].fp));
        end

        // Frame 2 clears; request withdrawn mid-frame must not cut it short
        clear_en = 1'b1;
        run_to(136);
        check("frame2_start_rd_en", 32'(fb_rd_en),   32'd1);
        check("frame2_start_addr",  32'(fb_rd_addr), 32'd0);
        run_to(180);
        clear_en = 1'b0;

        // Drop enable mid frame 3; scan must finish the frame then idle
        run_to(300);
        enable = 1'b0;
        run_to(406);
        check("idle_rd_addr", 32'(fb_rd_addr), 32'd0);
        run_to(440);

        // Restart, then assert reset asynchronously mid-line
        enable = 1'b1;
        run_to(445);
        check("pre_reset_de",    32'(de),       32'd1);
        check("pre_reset_rd_en", 32'(fb_rd_en), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        repeat (2) @(negedge clk);
        check_reset_outputs("held_reset");

        // Per-frame read order and coverage
        for (int f = 0; f < 3; f++) begin
            int n, bad;
            n = 0; bad = 0;
            for (int kk = f*FRAME + 1; kk <= (f+1)*FRAME; kk++) begin
                if (h_rd_en[kk]) begin
                    if (h_rd_addr[kk] != AW'(n)) bad++;
                    n++;
                end
            end
            check($sformatf("rd_count_f%0d", f+1), 32'(n),   32'd32);
            check($sformatf("rd_order_f%0d", f+1), 32'(bad), 32'd0);
        end

        // Display enable and colour per frame (outputs trail the counters by 2)
        begin
            int exp_fff[3];
            exp_fff[0] = 16; exp_fff[1] = 16; exp_fff[2] = 0;
            for (int f = 0; f < 3; f++) begin
                int nde, nfff;
                nde = 0; nfff = 0;
                for (int kk = f*FRAME + 3; kk <= (f+1)*FRAME + 2; kk++) begin
                    if (h_de[kk]) nde++;
                    if (h_de[kk] && h_rgb[kk] == 12'hFFF) nfff++;
                end
                check($sformatf("de_count_f%0d", f+1),  32'(nde),  32'd32);
                check($sformatf("fg_count_f%0d", f+1),  32'(nfff), 32'(exp_fff[f]));
            end
        end

        // Blanked colour and sync edge spacing over the whole run
        begin
            int bad_rgb, hfall, hbad, vfall;
            bad_rgb = 0; hfall = 0; hbad = 0; vfall = 0;
            for (int kk = 1; kk <= 440; kk++) begin
                if (!h_de[kk] && h_rgb[kk] != 12'h000) bad_rgb++;
                if (!h_hs[kk] && h_hs[kk-1]) begin
                    hfall++;
                    if (kk % 15 != 13) hbad++;
                end
                if (!h_vs[kk] && h_vs[kk-1]) vfall++;
            end
            check("rgb_blank_when_no_de", 32'(bad_rgb), 32'd0);
            check("hsync_fall_count",     32'(hfall),   32'd27);
            check("hsync_line_period",    32'(hbad),    32'd0);
            check("vsync_fall_count",     32'(vfall),   32'd3);
        end

        // Frame pulse: one rising edge and 15 clocks high per frame
        for (int f = 0; f < 3; f++) begin
            int nhigh, nrise;
            nhigh = 0; nrise = 0;
            for (int kk = f*FRAME + 1; kk <= (f+1)*FRAME; kk++) begin
                if (h_fp[kk]) nhigh++;
                if (h_fp[kk] && !h_fp[kk-1]) nrise++;
            end
            check($sformatf("fp_high_f%0d", f+1), 32'(nhigh), 32'd15);
            check($sformatf("fp_rise_f%0d", f+1), 32'(nrise), 32'd1);
        end

        // Clear strobes: 2 clocks after the read of the same address, only in frame 2
        begin
            int ncl[4];
            int bad;
            for (int f = 0; f < 4; f++) ncl[f] = 0;
            bad = 0;
            for (int kk = 3; kk <= 440; kk++) begin
                if (h_clr_en[kk]) begin
                    if (!(h_rd_en[kk-2] && h_rd_addr[kk-2] == h_clr_addr[kk])) bad++;
                    if ((kk - 3) / FRAME < 3) ncl[(kk - 3) / FRAME]++;
                    else ncl[3]++;
                end
            end
            check("clr_count_f1",   32'(ncl[0]), 32'd0);
            check("clr_count_f2",   32'(ncl[1]), 32'd32);
            check("clr_count_f3",   32'(ncl[2]), 32'd0);
            check("clr_count_idle", 32'(ncl[3]), 32'd0);
            check("clr_alignment",  32'(bad),    32'd0);
        end

        // Idle after the enable drop: nothing read, outputs blank, no frame pulse
        begin
            int nrd, nact;
            nrd = 0; nact = 0;
            for (int kk = 406; kk <= 440; kk++) if (h_rd_en[kk]) nrd++;
            for (int kk = 408; kk <= 440; kk++)
                if (h_de[kk] || !h_hs[kk] || !h_vs[kk] || h_fp[kk]) nact++;
            check("idle_reads",    32'(nrd),  32'd0);
            check("idle_outputs",  32'(nact), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard stop if the sequence above ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete, got timeout, want finish");
        $fatal(1);
    end

endmodule

// File: doc/framebuffer_scanout.md
Name: framebuffer_scanout

Overview:
- Pixel-clock-domain (25.2 MHz) reader side of the 1-bit monochrome framebuffer that the sample-drawing block writes from the 100 MHz domain.
- Generates 640x480@60 VGA timing and reads the framebuffer in raster order through the RAM's second port.
- Drives 12-bit RGB with hsync/vsync, and produces frame_pulse, which the writer side synchronises and edge-detects to start drawing a new frame.
- Optionally clears each pixel after reading it, so every frame starts blank.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- ADDR_WIDTH, $clog2(H_ACTIVE*V_ACTIVE), framebuffer address width (19)
- RD_LATENCY, 1, framebuffer read latency in clocks (1..3)
- FG_COLOR, 12'hFFF, RGB when pixel bit = 1
- BG_COLOR, 12'h000, RGB when pixel bit = 0

Ports:
- clk  in  1  pixel clock
- resetn  in  1  asynchronous, active-low reset
- enable  in  1  scan enable; low holds the timing at origin with outputs blanked
- clear_en  in  1  clear-after-read request, sampled once per frame
- fb_rd_addr  out  ADDR_WIDTH  framebuffer read address
- fb_rd_en  out  1  read strobe
- fb_rd_data  in  1  pixel bit, valid RD_LATENCY clocks after fb_rd_en
- fb_clr_addr  out  ADDR_WIDTH  address to clear
- fb_clr_en  out  1  write-0 strobe on the same RAM port
- hsync  out  1  active low
- vsync  out  1  active low
- de  out  1  display enable (active video)
- rgb  out  12  {R[3:0],G[3:0],B[3:0]}
- frame_pulse  out  1  high for the whole first blanking line after active video

Behaviour:
- Reset (async assert, sync release): h_cnt=0, v_cnt=0, address=0.
  - All outputs reset to: hsync=1, vsync=1, de=0, rgb=0, fb_rd_en=0, fb_clr_en=0, frame_pulse=0, both addresses 0.
  - All pipeline stages are flushed.
- States: IDLE, SCAN.
  - IDLE -> SCAN when enable=1, entering at h=0, v=0.
  - SCAN -> IDLE when enable=0, but only at the end of a frame (h=H_TOTAL-1, v=V_TOTAL-1), so frames are never truncated.
  - In IDLE: counters held at 0, sync outputs inactive, de=0, rgb=0.
- Counters (SCAN):
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 525.
  - h_cnt wraps at H_TOTAL-1; v_cnt increments on each h wrap and wraps at V_TOTAL-1.
- Stage-0 signals, then delayed:
  - active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - hs = (h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]).
  - vs = the same rule applied to v_cnt.
  - active, hs and vs pass through an RD_LATENCY-deep delay line, then one output register.
- Address:
  - Incremental, no multiplier.
  - fb_rd_en = active at stage 0; fb_rd_addr = addr, with addr incremented after each active pixel.
  - addr resets to 0 at h=0, v=0.
  - Final address is H_ACTIVE*V_ACTIVE-1 = 307199 and must never be exceeded.
- Output timing:
  - rgb/de/hsync/vsync are registered, RD_LATENCY+1 clocks after the corresponding counter value.
  - rgb = de ? (fb_rd_data ? FG_COLOR : BG_COLOR) : 0.
- Clear-after-read:
  - clear_en is latched into clr_frame at h=0, v=0.
  - When clr_frame=1, fb_clr_en pulses RD_LATENCY+1 clocks after each fb_rd_en, with fb_clr_addr equal to the delayed read address, so the write follows the read and never overwrites unread data.
  - A change of clear_en mid-frame has no effect until the next frame.
- frame_pulse:
  - Registered; rises at h=0, v=V_ACTIVE and falls at h=0, v=V_ACTIVE+1, i.e. high for exactly H_TOTAL clocks.
  - The wide pulse guarantees the 100 MHz side's 3-flop synchroniser and edge detect catch it.
  - No pulse is generated in IDLE.
- Reset mid-frame: returns to IDLE immediately and outputs take their reset values asynchronously. A pending clear strobe is dropped; the row is cleared on the next frame.
- Simultaneous events: at h=H_TOTAL-1, v=V_TOTAL-1 with enable=0, the block goes to IDLE and does not start a new frame.

Decomposition:
- Package vga_pkg:
  - 800x525 timing constants and derived H_TOTAL/V_TOTAL.
  - Colour localparams and the 2-bit state encoding.
- Sub-module vga_timing_gen:
  - Counters, hs/vs/active, frame origin and frame_pulse.
  - framebuffer_scanout adds address generation, the latency pipeline, colour mapping and clear logic.

Test Plan:
- Reset then enable=1, RD_LATENCY=1:
  - first fb_rd_en at clk 1 with addr 0; de rises at clk 3.
  - hsync low for 96 clocks starting at h=656+2; line period 800; frame period 420000 clocks.
- Pattern test, model returns bit = addr[0]: rgb alternates FFF/000 across active pixels; rgb=0 whenever de=0.
- Address coverage: over one frame, 307200 fb_rd_en pulses, addresses 0..307199 each exactly once; last address 307199 at h=639, v=479.
- frame_pulse: rises at v=480, h=0; high for exactly 800 clocks; exactly once per frame.
- clear_en=1 toggled to 0 mid-frame:
  - current frame still produces 307200 fb_clr_en, each 2 clocks after the read of the same address (RD_LATENCY=1).
  - next frame produces 0 clears.
- enable dropped mid-frame: scanning continues to v=524, h=799, then IDLE with de=0, vsync=1 and no frame_pulse. An async resetn assertion mid-line forces all outputs to reset values without waiting for a clock edge.
